// File: rtl/eth_tx_pkg.sv
// ============================================================================
// Module   : eth_tx_pkg
// Brief    : Shared state encoding and frame constants for the Ethernet TX framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MAC  = 3'd2,
        ST_IPH  = 3'd3,
        ST_PAY  = 3'd4,
        ST_PAD  = 3'd5,
        ST_FCS  = 3'd6,
        ST_IFG  = 3'd7
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
    localparam logic [10:0] MIN_PAYLOAD = 11'd26;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam int          HDR_BYTES   = 20;

endpackage

`default_nettype wire

// File: rtl/eth_tx_framer_crc32_d8.sv
// ============================================================================
// Module   : crc32_d8
// Brief    : Combinational reflected CRC-32 update for one byte per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c_w;

    always_comb begin
        c_w = crc_i ^ {24'h0, data_i};
        for (int b = 0; b < 8; b++) begin
            c_w = c_w[0] ? ((c_w >> 1) ^ CRC_POLY) : (c_w >> 1);
        end
        crc_o = c_w;
    end

endmodule

`default_nettype wire

// File: rtl/eth_tx_framer.sv
// ============================================================================
// Module   : eth_tx_framer
// Brief    : Buffers a 20-byte IPv4 header and streams a full Ethernet II frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter logic [47:0] P_DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] P_SRC_MAC = 48'h000A_3500_0001,
    parameter int unsigned P_IFG     = 12,
    parameter int unsigned P_MAX_LEN = 1480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_iph_wr_en,
    input  logic [4:0]  i_iph_idx,
    input  logic [7:0]  i_iph_byte,
    input  logic        i_start,
    input  logic [10:0] i_payload_len,
    input  logic [7:0]  i_pl_byte,
    output logic        o_pl_rd,
    output logic [7:0]  o_txd,
    output logic        o_txen,
    output logic        o_ready,
    output logic        o_done
);

    localparam logic [10:0] LEN_MAX  = 11'(P_MAX_LEN);
    localparam logic [10:0] IFG_LAST = 11'(P_IFG - 1);
    localparam logic [95:0] MAC_HDR  = {P_DST_MAC, P_SRC_MAC};

    tx_state_e   state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  hdr_q [HDR_BYTES];
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_seed_w, crc_next_w;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [10:0] len_clamp_w;
    logic        hdr_wr_w;

    assign len_clamp_w = (i_payload_len > LEN_MAX) ? LEN_MAX : i_payload_len;
    assign hdr_wr_w    = i_iph_wr_en && ready_q && (i_iph_idx < 5'(HDR_BYTES));

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 11'd1;
        done_d  = 1'b0;
        len_d   = (state_q == ST_IDLE) ? len_clamp_w : len_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_start) state_d = ST_PRE;
            end
            ST_PRE: if (cnt_q == 11'd7) begin
                state_d = ST_MAC;
                cnt_d   = '0;
            end
            ST_MAC: if (cnt_q == 11'd13) begin
                state_d = ST_IPH;
                cnt_d   = '0;
            end
            ST_IPH: if (cnt_q == 11'(HDR_BYTES - 1)) begin
                state_d = (len_q == '0) ? ST_PAD : ST_PAY;
                cnt_d   = '0;
            end
            ST_PAY: if (cnt_q == len_q - 11'd1) begin
                state_d = (len_q < MIN_PAYLOAD) ? ST_PAD : ST_FCS;
                cnt_d   = '0;
            end
            ST_PAD: if (cnt_q == MIN_PAYLOAD - 11'd1 - len_q) begin
                state_d = ST_FCS;
                cnt_d   = '0;
            end
            ST_FCS: if (cnt_q == 11'd3) begin
                state_d = ST_IFG;
                cnt_d   = '0;
            end
            ST_IFG: if (cnt_q == IFG_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered, so the byte is chosen from the state being entered
    always_comb begin
        txd_d   = 8'h00;
        txen_d  = 1'b1;
        ready_d = (state_d == ST_IDLE);
        case (state_d)
            ST_PRE: txd_d = (cnt_d[2:0] == 3'd7) ? SFD : PREAMBLE;
            ST_MAC: begin
                if (cnt_d[3:0] < 4'd12)
                    txd_d = MAC_HDR[(7'd88 - {cnt_d[3:0], 3'b000}) +: 8];
                else if (cnt_d[3:0] == 4'd12)
                    txd_d = ETYPE_IPV4[15:8];
                else
                    txd_d = ETYPE_IPV4[7:0];
            end
            ST_IPH: begin
                for (int i = 0; i < HDR_BYTES; i++) begin
                    if (cnt_d[4:0] == 5'(i)) txd_d = hdr_q[i];
                end
            end
            ST_PAY: txd_d = i_pl_byte;
            ST_PAD: txd_d = 8'h00;
            ST_FCS: txd_d = ~crc_q[{cnt_d[1:0], 3'b000} +: 8];
            default: txen_d = 1'b0;
        endcase
    end

    assign crc_seed_w = (state_d == ST_MAC && cnt_d == '0) ? CRC_INIT : crc_q;

    always_comb begin
        crc_d = crc_q;
        if (state_d == ST_MAC || state_d == ST_IPH || state_d == ST_PAY || state_d == ST_PAD)
            crc_d = crc_next_w;
    end

    crc32_d8 u_crc (
        .crc_i  (crc_seed_w),
        .data_i (txd_d),
        .crc_o  (crc_next_w)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            crc_q   <= CRC_INIT;
            txd_q   <= '0;
            txen_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < HDR_BYTES; i++) hdr_q[i] <= '0;
        end else if (hdr_wr_w) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                if (i_iph_idx == 5'(i)) hdr_q[i] <= i_iph_byte;
            end
        end
    end

    // Pop in the cycle whose FIFO head is captured into o_txd at the next edge
    assign o_pl_rd = (state_d == ST_PAY);
    assign o_txd   = txd_q;
    assign o_txen  = txen_q;
    assign o_ready = ready_q;
    assign o_done  = done_q;

endmodule

`default_nettype wire
